// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master side drives the request; the slave side (the converter)
// returns status and the packed BCD result.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ovf
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A conversion takes BIN_W SHIFT cycles plus one DONE cycle; the result and
// overflow flag are registered together with a one-cycle done pulse and then
// held until the next conversion completes.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_shift;
    logic               w_finish;

    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin;
    logic [SCR_W-1:0]   r_scr;
    logic [SCR_W-1:0]   w_adj;
    logic               r_ovf_acc;
    logic [SCR_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_done;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order across always blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control decode.
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                // Counter value 1 means this cycle consumes the last bit.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Add-3 correction: each scratch digit >= 5 gets +3 before the shift so
    // that doubling it carries correctly into the next decimal digit.
    always_comb begin
        w_adj = r_scr;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scr[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath: load on accept, shift one bit per SHIFT cycle,
    // publish result and overflow in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bin     <= '0;
            r_scr     <= '0;
            r_ovf_acc <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_bin     <= bus.bin_in;
                r_scr     <= '0;
                r_ovf_acc <= 1'b0;
                r_cnt     <= CNT_W'(BIN_W);
            end
            if (w_shift) begin
                r_scr     <= {w_adj[SCR_W-2:0], r_bin[BIN_W-1]};
                r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
                // Any bit pushed out of the top digit is lost magnitude.
                r_ovf_acc <= r_ovf_acc | w_adj[SCR_W-1];
                r_cnt     <= r_cnt - CNT_W'(1);
            end
            if (w_finish) begin
                r_bcd <= r_scr;
                r_ovf <= r_ovf_acc;
            end
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.bcd_out = r_bcd;
    assign bus.ovf     = r_ovf;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 3-digit and a 2-digit instance,
// expected results queued at stimulus time and compared on each done pulse.
module tb_bin2bcd_seq;
    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t prev_a;
    bit   have_prev_a = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) a_if ();
    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) b_if ();

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digit extraction by division.
    function automatic exp_t model(input int v, input int digits);
        exp_t e;
        int   p = 1;
        e.bcd = '0;
        for (int d = 0; d < digits; d++) begin
            e.bcd[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        e.ovf = (v >= p);
        return e;
    endfunction

    task automatic set_in(input int which, input logic s, input logic [7:0] v);
        if (which == 0) begin
            a_if.start  = s;
            a_if.bin_in = v;
        end else begin
            b_if.start  = s;
            b_if.bin_in = v;
        end
    endtask

    function automatic logic get_done(input int which);
        return (which == 0) ? a_if.done : b_if.done;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? a_if.busy : b_if.busy;
    endfunction

    // One conversion: drive start, queue expectation, wait for done and
    // check latency. poke_at>0 pulses start with poke_v mid-conversion.
    task automatic convert(input int which, input logic [7:0] v,
                           input int poke_at, input logic [7:0] poke_v);
        exp_t e;
        int   n = 0;
        bit   found = 1'b0;
        e = model(int'(v), (which == 0) ? 3 : 2);
        if (which == 0) qa.push_back(e);
        else            qb.push_back(e);
        set_in(which, 1'b1, v);
        @(posedge clk);
        #1;
        set_in(which, 1'b0, ~v);
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_on", get_busy(which), 1);
                if (which == 0 && have_prev_a)
                    check("hold_on_start", a_if.bcd_out, prev_a.bcd);
            end
            if (poke_at > 0 && n == poke_at) set_in(which, 1'b1, poke_v);
            if (poke_at > 0 && n == poke_at + 1) set_in(which, 1'b0, poke_v);
            if (get_done(which)) found = 1'b1;
        end
        if (!found) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", n, 10);
            check("busy_off_at_done", get_busy(which), 0);
        end
        if (which == 0) begin
            prev_a      = e;
            have_prev_a = 1'b1;
        end
    endtask

    task automatic expect_quiet(input int which, input int cycles, input string tag);
        int cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (get_done(which)) cnt++;
        end
        check(tag, cnt, 0);
    endtask

    // Scoreboard compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (a_if.done === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_done", 1, 0);
            end else begin
                e = qa.pop_front();
                check("a_ovf", a_if.ovf, e.ovf);
                if (!e.ovf) check("a_bcd", a_if.bcd_out, e.bcd);
            end
        end
        if (b_if.done === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_done", 1, 0);
            end else begin
                e = qb.pop_front();
                check("b_ovf", b_if.ovf, e.ovf);
                if (!e.ovf) check("b_bcd", b_if.bcd_out, e.bcd);
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_in(0, 1'b0, 8'd0);
        set_in(1, 1'b0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_bcd", a_if.bcd_out, 0);
        check("rst_ovf", a_if.ovf, 0);
        check("rst_busy", a_if.busy, 0);
        check("rst_done", a_if.done, 0);

        // Boundary and directed values.
        convert(0, 8'd0,   0, 8'd0);
        convert(0, 8'd255, 0, 8'd0);
        convert(0, 8'd99,  0, 8'd0);
        convert(0, 8'd100, 0, 8'd0);
        for (int i = 0; i < 6; i++) begin
            convert(0, 8'($urandom_range(0, 255)), 0, 8'd0);
        end

        // start held high: back-to-back conversions every 10 cycles.
        begin
            int ndone = 0;
            int nlow  = 0;
            int last  = -1;
            for (int i = 0; i < 4; i++) qa.push_back(model(37, 3));
            set_in(0, 1'b1, 8'd37);
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (i == 39) set_in(0, 1'b0, 8'd37);
                @(negedge clk);
                if (!a_if.busy) nlow++;
                if (a_if.done) begin
                    if (last >= 0) check("b2b_period", i - last, 10);
                    last = i;
                    ndone++;
                end
            end
            check("b2b_done_count", ndone, 4);
            check("b2b_idle_cycles", nlow, 4);
            prev_a = model(37, 3);
        end

        // start during busy is ignored.
        convert(0, 8'd200, 4, 8'd7);
        expect_quiet(0, 12, "ignored_start_no_done");

        // Reset mid-conversion discards the partial result.
        qa.push_back(model(150, 3));
        set_in(0, 1'b1, 8'd150);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_bcd", a_if.bcd_out, 0);
        check("midrst_ovf", a_if.ovf, 0);
        check("midrst_busy", a_if.busy, 0);
        check("midrst_done", a_if.done, 0);
        void'(qa.pop_front());
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_quiet(0, 12, "midrst_no_done");
        prev_a.bcd = '0;
        convert(0, 8'd150, 0, 8'd0);

        // Undersized result: 2 digits.
        convert(1, 8'd255, 0, 8'd0);
        convert(1, 8'd99,  0, 8'd0);

        repeat (3) @(negedge clk);
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
